// File: rtl/arb_client_pkg.sv
// rtl/arb_client_pkg.sv - shared types and constants for the two-port arbiter client
package arb_client_pkg;

    localparam int NUM_PORTS = 2;

    typedef logic [0:0] port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // Saturating 8-bit increment used by the wait-time statistic.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/arb_client_fifo.sv
// rtl/arb_client_fifo.sv - synchronous per-port transaction queue
// Ports: clk, rst (sync, active-high); push/din write side; pop/dout read side
// (dout is the current head, valid while !empty); full, empty, count status.
// Push while full and pop while empty are ignored.
module arb_client_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_client_2port.sv
// rtl/arb_client_2port.sv - requester-side front end for a 2-request round-robin arbiter
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready per-port upstream
// (in_data port i = in_data[i*WIDTH +: WIDTH]); requests to arbiter, grants from arbiter
// (answer previous-cycle requests); out_valid/out_data/out_port registered granted output.
// Optional ARB_CLIENT_STATS_EN: grant_cnt0/grant_cnt1 (16b wrap), wait_max (8b saturating).
module arb_client_2port
    import arb_client_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      in_valid,
    input  logic [NUM_PORTS*WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]      in_ready,
    output logic [NUM_PORTS-1:0]      requests,
    input  logic [NUM_PORTS-1:0]      grants,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output port_id_t                  out_port
`ifdef ARB_CLIENT_STATS_EN
    ,
    output logic [15:0]               grant_cnt0,
    output logic [15:0]               grant_cnt1,
    output logic [7:0]                wait_max
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]     head  [NUM_PORTS];
    logic [CW-1:0]        count [NUM_PORTS];
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign in_ready[i] = !full[i];
        assign push[i]     = in_valid[i] && !full[i];
        // A grant answering this port's last request will remove one entry this edge,
        // so only keep asking if something beyond that entry remains.
        assign requests[i] = (count[i] > {{(CW-1){1'b0}}, grants[i]});

        arb_client_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .din   (in_data[i*WIDTH +: WIDTH]),
            .pop   (pop[i]),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
        );
    end

    // Grants to an empty queue are dropped; a two-hot grant is resolved in favour of port 0.
    assign pop[0] = grants[0] && !empty[0];
    assign pop[1] = (grants == 2'b10) && !empty[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= PORT0;
        end else begin
            out_valid <= |pop;
            if (pop[0]) begin
                out_data <= head[0];
                out_port <= PORT0;
            end else if (pop[1]) begin
                out_data <= head[1];
                out_port <= PORT1;
            end
        end
    end

`ifdef ARB_CLIENT_STATS_EN
    logic [7:0] wait_cnt [NUM_PORTS];
    logic [7:0] wait_nxt [NUM_PORTS];
    logic [7:0] wait_peak;

    // A cycle counts as waiting when the port asks and is not served on that edge.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            wait_nxt[i] = 8'd0;
            if (requests[i] && !pop[i]) begin
                wait_nxt[i] = sat_inc8(wait_cnt[i]);
            end
        end
        wait_peak = (wait_nxt[0] > wait_nxt[1]) ? wait_nxt[0] : wait_nxt[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            wait_max   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (pop[0]) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (pop[1]) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt[i] <= wait_nxt[i];
            end
            if (wait_peak > wait_max) begin
                wait_max <= wait_peak;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arb_client_2port.sv
// tb/tb_arb_client_2port.sv - self-checking bench with queue model and registered RR arbiter model
module tb_arb_client_2port;
    import arb_client_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         in_valid;
    logic [2*WIDTH-1:0] in_data;
    logic [1:0]         in_ready;
    logic [1:0]         requests;
    logic [1:0]         grants;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    port_id_t           out_port;
`ifdef ARB_CLIENT_STATS_EN
    logic [15:0]        grant_cnt0;
    logic [15:0]        grant_cnt1;
    logic [7:0]         wait_max;
`endif

    always #5 clk = ~clk;

    arb_client_2port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .requests  (requests),
        .grants    (grants),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port)
`ifdef ARB_CLIENT_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .wait_max   (wait_max)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference state: per-port queues, round-robin arbiter register, grant tallies.
    logic [WIDTH-1:0] mq [2][$];
    logic [1:0]       arb_g;
    bit               prio;
    int               gcnt0;
    int               gcnt1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the model,
    // then check the registered output after the edge.
    task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input bit use_arb, input logic [1:0] fg);
        logic [1:0] g;
        logic [1:0] rdy;
        logic [1:0] req;
        logic       ev;
        logic [7:0] ed;
        logic       ep;
        g        = use_arb ? arb_g : fg;
        in_valid = v;
        in_data  = {d1, d0};
        grants   = g;
        #1;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = (mq[i].size() != DEPTH);
            req[i] = (mq[i].size() > int'(g[i]));
        end
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("requests", 32'(requests), 32'(req));

        ev = 1'b0;
        ed = '0;
        ep = 1'b0;
        if (g[0] && mq[0].size() > 0) begin
            ev = 1'b1; ed = mq[0].pop_front(); ep = 1'b0; gcnt0++;
        end else if (g == 2'b10 && mq[1].size() > 0) begin
            ev = 1'b1; ed = mq[1].pop_front(); ep = 1'b1; gcnt1++;
        end
        if (v[0] && rdy[0]) mq[0].push_back(d0);
        if (v[1] && rdy[1]) mq[1].push_back(d1);

        if (use_arb) begin
            if (req == 2'b11) begin
                arb_g = prio ? 2'b10 : 2'b01;
                prio  = ~prio;
            end else if (req[0]) begin
                arb_g = 2'b01; prio = 1'b1;
            end else if (req[1]) begin
                arb_g = 2'b10; prio = 1'b0;
            end else begin
                arb_g = 2'b00;
            end
        end else begin
            arb_g = 2'b00;
        end

        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            check("out_data", 32'(out_data), 32'(ed));
            check("out_port", 32'(out_port), 32'(ep));
        end
    endtask

    task automatic do_reset(input logic [1:0] g);
        in_valid = 2'b00;
        grants   = g;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        grants = 2'b00;
        mq[0].delete();
        mq[1].delete();
        arb_g = 2'b00;
        prio  = 1'b0;
        gcnt0 = 0;
        gcnt1 = 0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_port", 32'(out_port), 32'd0);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd3);
        check("rst_requests", 32'(requests), 32'd0);
`ifdef ARB_CLIENT_STATS_EN
        check("rst_grant_cnt0", 32'(grant_cnt0), 32'd0);
        check("rst_grant_cnt1", 32'(grant_cnt1), 32'd0);
        check("rst_wait_max", 32'(wait_max), 32'd0);
`endif
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (mq[0].size() > 0 || mq[1].size() > 0 || arb_g != 2'b00); k++) begin
            step(2'b00, 8'h00, 8'h00, 1'b1, 2'b00);
        end
        check("drain_q0_empty", 32'(mq[0].size()), 32'd0);
        check("drain_q1_empty", 32'(mq[1].size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 2'b00;
        in_data  = '0;
        grants   = 2'b00;
        @(posedge clk);
        #1;
        do_reset(2'b00);

        // Single entry on port 0 through the whole request/grant/output path.
        step(2'b01, 8'hA1, 8'h00, 1'b1, 2'b00);
        for (int k = 0; k < 4; k++) step(2'b00, 8'h00, 8'h00, 1'b1, 2'b00);

        // Three entries in each queue, then let the arbiter alternate.
        do_reset(2'b00);
        for (int k = 0; k < 3; k++) step(2'b11, 8'h10 + 8'(k), 8'h20 + 8'(k), 1'b0, 2'b00);
        drain();

        // Fill port 1 to DEPTH with no grants, then release one slot.
        do_reset(2'b00);
        for (int k = 0; k < DEPTH + 1; k++) step(2'b10, 8'h00, 8'h30 + 8'(k), 1'b0, 2'b00);
        step(2'b00, 8'h00, 8'h00, 1'b0, 2'b10);
        step(2'b00, 8'h00, 8'h00, 1'b0, 2'b00);

        // Protocol errors: grant to an empty queue, and a two-hot grant.
        do_reset(2'b00);
        step(2'b00, 8'h00, 8'h00, 1'b0, 2'b10);
        step(2'b00, 8'h00, 8'h00, 1'b0, 2'b01);
        step(2'b11, 8'h41, 8'h51, 1'b0, 2'b00);
        step(2'b11, 8'h42, 8'h52, 1'b0, 2'b00);
        step(2'b00, 8'h00, 8'h00, 1'b0, 2'b11);
        step(2'b00, 8'h00, 8'h00, 1'b0, 2'b11);
        drain();

        // Reset with two entries queued and a grant in flight.
        do_reset(2'b00);
        step(2'b01, 8'h61, 8'h00, 1'b0, 2'b00);
        step(2'b01, 8'h62, 8'h00, 1'b1, 2'b00);
        do_reset(arb_g);
        step(2'b00, 8'h00, 8'h00, 1'b1, 2'b00);

`ifdef ARB_CLIENT_STATS_EN
        // Five grants on port 0 and three on port 1 under contention.
        do_reset(2'b00);
        for (int k = 0; k < 5; k++) begin
            step({k < 3, 1'b1}, 8'h70 + 8'(k), 8'h80 + 8'(k), 1'b1, 2'b00);
        end
        drain();
        check("stats_model_cnt0", 32'(gcnt0), 32'd5);
        check("stats_model_cnt1", 32'(gcnt1), 32'd3);
        check("stats_grant_cnt0", 32'(grant_cnt0), 32'(gcnt0));
        check("stats_grant_cnt1", 32'(grant_cnt1), 32'(gcnt1));
        check("stats_wait_max_ge1", 32'(wait_max >= 8'd1), 32'd1);
`endif

        // Randomized traffic against the arbiter model.
        do_reset(2'b00);
        for (int k = 0; k < 400; k++) begin
            step(2'($urandom), 8'($urandom), 8'($urandom), 1'b1, 2'b00);
        end
        drain();
`ifdef ARB_CLIENT_STATS_EN
        check("rand_grant_cnt0", 32'(grant_cnt0), 32'(gcnt0));
        check("rand_grant_cnt1", 32'(grant_cnt1), 32'(gcnt1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
